block_move_ctrl: RTL
====================

// Module: block_move_ctrl
// PURPOSE
//  Move controller that drives the falling-block position register: proposes next x/y/rotation from
//  player commands and gravity, validates each proposal via a collision-check handshake, then issues
//  a one-cycle refresh (commit) or, on landing, lock + err (respawn at SPAWN_X/SPAWN_Y/rot 0).
//  Sits between input debounce/gravity timer and the position register; its outputs feed that register.
// PARAMETERS
//  POS_W   10  width of x/y/rotate buses
//  X_MAX   19  rightmost legal column
//  Y_MAX   39  bottom row; a down move from Y_MAX is a landing
//  ROT_N   4   number of rotation states; rotate wraps modulo ROT_N
//  CHK_TO  15  max cycles waiting chk_ack before forcing a hit
// PORTS
//  clk        in  1      system clock
//  rst_n      in  1      asynchronous active-low reset
//  cur_x/cur_y/cur_rot in POS_W  current committed position (from position register)
//  btn_left/btn_right/btn_rot/btn_drop in 1  single-cycle command pulses
//  grav_tick  in  1      single-cycle gravity pulse (one row down)
//  chk_req    out 1      collision check request, held until chk_ack
//  chk_x/chk_y/chk_rot out POS_W  candidate under check (stable while chk_req)
//  chk_ack    in  1      checker response valid
//  chk_hit    in  1      candidate collides (sampled with chk_ack)
//  block_pos_x_in/block_pos_y_in/rotate_in out POS_W  value to commit
//  refresh    out 1      1-cycle commit strobe
//  err        out 1      1-cycle respawn strobe
//  lock       out 1      1-cycle "block landed, merge into board" strobe
//  game_over  out 1      sticky; spawn position collided
// BEHAVIOUR
//  Reset: state IDLE; chk_req/refresh/err/lock/game_over=0; chk_*/commit buses=0; pending flags cleared.
//  Pending: each command/tick sets a sticky flag; flag cleared when serviced. Duplicate pulses merge.
//  Priority when leaving IDLE: rot > left > right > drop > grav. Same-cycle drop+grav = one down step.
//  States: IDLE -> PROPOSE -> WAIT -> {COMMIT | IDLE | LOCK}; LOCK -> SPAWN -> SPAWN_WAIT -> {IDLE|OVER}.
//  PROPOSE (1 cyc): candidate = cur with rot=(cur_rot+1)%ROT_N, x-1, x+1 or y+1.
//   left at x=0 or right at x=X_MAX: reject immediately -> IDLE, no chk_req.
//   down at y=Y_MAX: treated as hit -> LOCK, no chk_req.
//  WAIT: chk_req=1 with stable candidate; on chk_ack: hit=0 -> COMMIT; hit=1 -> LOCK if down else IDLE.
//   CHK_TO cycles without ack -> treated as hit. chk_req drops the cycle after ack.
//  COMMIT: refresh=1 for one cycle with block_pos_*_in = candidate -> IDLE. Latency cmd->refresh
//   is 4 cycles with a same-cycle ack (min).
//  LOCK: lock=1 one cycle; all pending flags cleared. SPAWN: err=1 one cycle, then check
//   (SPAWN_X,0,0) via handshake; hit -> OVER (game_over=1, sticky, ignores all input until reset).
//  refresh and err never asserted together; at most one handshake outstanding.
//  Async reset mid-handshake: chk_req drops immediately; no refresh/err emitted.
//  Widths: all arithmetic in POS_W bits unsigned; rotate wrap by compare, not modulo operator.
// CONFIGURATION
//  HARD_DROP_EN defined: btn_drop repeats down steps (PROPOSE/WAIT/COMMIT loop, other pending
//   commands held off) until hit, then LOCK; one refresh per row moved.
//  Undefined: btn_drop is a soft drop = single down step, identical to grav_tick.
// STRUCTURE
//  tetris_pkg: state enum, cmd enum {CMD_ROT,CMD_LEFT,CMD_RIGHT,CMD_DOWN}, SPAWN_X=9, SPAWN_Y=0.
//  Sub-module block_cmd_arb: sticky pending flags + fixed-priority select + clear-on-service.
//  FSM, candidate arithmetic, timeout counter in block_move_ctrl.
// TESTING
//  cur=(9,5,0), btn_left, ack no-hit -> chk=(8,5,0), refresh with x_in=8 after 4 cycles.
//  cur=(0,5,0), btn_left -> no chk_req, no refresh, back to IDLE in 2 cycles.
//  cur rot=3, btn_rot, ack no-hit -> rotate_in=0; btn_rot+btn_right same cycle -> rotate first, then right.
//  grav_tick at y=12, ack hit -> lock pulse, then err, then spawn check (9,0,0); hit -> game_over=1.
//  Checker never acks -> after 15 WAIT cycles treated as hit (down -> lock; left -> IDLE).
//  HARD_DROP_EN, cur y=30, hit at y=36 -> 5 refreshes (y 31..35), then lock; undefined -> 1 refresh y=31.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types and constants for the falling-block move controller.
package tetris_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROPOSE,
    ST_WAIT,
    ST_COMMIT,
    ST_LOCK,
    ST_SPAWN,
    ST_SPAWN_WAIT,
    ST_OVER
  } state_e;

  typedef enum logic [1:0] {
    CMD_ROT,
    CMD_LEFT,
    CMD_RIGHT,
    CMD_DOWN
  } cmd_e;

  localparam int SPAWN_X = 9;
  localparam int SPAWN_Y = 0;

endpackage

// File: rtl/block_move_ctrl_if.sv
// Collision-check handshake between the move controller (master) and the board checker (slave).
interface block_move_ctrl_if #(
  parameter int POS_W = 10
);
  logic             chk_req;
  logic [POS_W-1:0] chk_x;
  logic [POS_W-1:0] chk_y;
  logic [POS_W-1:0] chk_rot;
  logic             chk_ack;
  logic             chk_hit;

  modport master (
    output chk_req, chk_x, chk_y, chk_rot,
    input  chk_ack, chk_hit
  );

  modport slave (
    input  chk_req, chk_x, chk_y, chk_rot,
    output chk_ack, chk_hit
  );
endinterface

// File: rtl/block_cmd_arb.sv
// Sticky command flags with fixed priority rot > left > right > down and clear-on-service.
// HARD_DROP_EN: btn_drop gets its own flag and is reported as a hard drop via sel_hard.
module block_cmd_arb
  import tetris_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic btn_rot,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_drop,
  input  logic grav_tick,
  input  logic take,
  input  logic clear_all,
  output logic pending,
  output cmd_e sel_cmd,
  output logic sel_hard
);

  logic p_rot, p_left, p_right, p_down, p_hard;
  logic down_set, take_down;

  always_comb begin
    sel_cmd = CMD_DOWN;
    if (p_rot)        sel_cmd = CMD_ROT;
    else if (p_left)  sel_cmd = CMD_LEFT;
    else if (p_right) sel_cmd = CMD_RIGHT;
  end

  assign pending   = p_rot | p_left | p_right | p_down | p_hard;
  assign sel_hard  = p_hard;
  assign take_down = take && (sel_cmd == CMD_DOWN);

  // A new pulse in the same cycle as its service wins, so it is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_rot   <= 1'b0;
      p_left  <= 1'b0;
      p_right <= 1'b0;
      p_down  <= 1'b0;
    end else if (clear_all) begin
      p_rot   <= 1'b0;
      p_left  <= 1'b0;
      p_right <= 1'b0;
      p_down  <= 1'b0;
    end else begin
      p_rot   <= btn_rot   | (p_rot   & ~(take && sel_cmd == CMD_ROT));
      p_left  <= btn_left  | (p_left  & ~(take && sel_cmd == CMD_LEFT));
      p_right <= btn_right | (p_right & ~(take && sel_cmd == CMD_RIGHT));
      p_down  <= down_set  | (p_down  & ~take_down);
    end
  end

`ifdef HARD_DROP_EN
  assign down_set = grav_tick;

  // Servicing a hard drop also absorbs any pending gravity step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         p_hard <= 1'b0;
    else if (clear_all) p_hard <= 1'b0;
    else                p_hard <= btn_drop | (p_hard & ~take_down);
  end
`else
  assign down_set = grav_tick | btn_drop;
  assign p_hard   = 1'b0;
`endif

endmodule

// File: rtl/block_move_ctrl.sv
// Falling-block move controller: proposes moves, validates them through the collision-check
// handshake, commits (refresh) or locks and respawns. Hard drop is enabled by HARD_DROP_EN.
//
// state         | meaning
// ST_IDLE       | waiting for a pending command
// ST_PROPOSE    | build candidate from cur_*, reject at walls, land at bottom
// ST_WAIT       | chk_req held until ack or timeout
// ST_COMMIT     | refresh strobe with candidate on commit bus
// ST_LOCK       | lock strobe, pending commands flushed
// ST_SPAWN      | err strobe, spawn position on commit bus
// ST_SPAWN_WAIT | collision check of the spawn position
// ST_OVER       | spawn collided; frozen until reset
module block_move_ctrl
  import tetris_pkg::*;
#(
  parameter int POS_W  = 10,
  parameter int X_MAX  = 19,
  parameter int Y_MAX  = 39,
  parameter int ROT_N  = 4,
  parameter int CHK_TO = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [POS_W-1:0] cur_x,
  input  logic [POS_W-1:0] cur_y,
  input  logic [POS_W-1:0] cur_rot,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_rot,
  input  logic             btn_drop,
  input  logic             grav_tick,
  block_move_ctrl_if.master chk,
  output logic [POS_W-1:0] block_pos_x_in,
  output logic [POS_W-1:0] block_pos_y_in,
  output logic [POS_W-1:0] rotate_in,
  output logic             refresh,
  output logic             err,
  output logic             lock,
  output logic             game_over
);

  localparam int               TO_W    = $clog2(CHK_TO + 1);
  localparam logic [TO_W-1:0]  TO_INIT = TO_W'(CHK_TO - 1);
  localparam logic [POS_W-1:0] X_LAST  = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] Y_LAST  = POS_W'(Y_MAX);
  localparam logic [POS_W-1:0] R_LAST  = POS_W'(ROT_N - 1);
  localparam logic [POS_W-1:0] SP_X    = POS_W'(SPAWN_X);
  localparam logic [POS_W-1:0] SP_Y    = POS_W'(SPAWN_Y);

  state_e           state;
  cmd_e             cmd_q, sel_cmd;
  logic             hard_q, sel_hard, pending, take, clear_all;
  logic             req, resolve, hit_eff;
  logic [POS_W-1:0] cand_x, cand_y, cand_rot, rot_nxt;
  logic [TO_W-1:0]  to_cnt;

  block_cmd_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_rot   (btn_rot),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_drop  (btn_drop),
    .grav_tick (grav_tick),
    .take      (take),
    .clear_all (clear_all),
    .pending   (pending),
    .sel_cmd   (sel_cmd),
    .sel_hard  (sel_hard)
  );

  assign take      = (state == ST_IDLE) && pending;
  assign clear_all = (state == ST_LOCK);
  assign rot_nxt   = (cur_rot >= R_LAST) ? '0 : cur_rot + POS_W'(1);

  // A silent checker is treated exactly like a collision.
  assign resolve = chk.chk_ack || (to_cnt == '0);
  assign hit_eff = chk.chk_ack ? chk.chk_hit : 1'b1;

  assign chk.chk_req = req;
  assign chk.chk_x   = cand_x;
  assign chk.chk_y   = cand_y;
  assign chk.chk_rot = cand_rot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cmd_q          <= CMD_ROT;
      hard_q         <= 1'b0;
      req            <= 1'b0;
      cand_x         <= '0;
      cand_y         <= '0;
      cand_rot       <= '0;
      to_cnt         <= '0;
      block_pos_x_in <= '0;
      block_pos_y_in <= '0;
      rotate_in      <= '0;
      refresh        <= 1'b0;
      err            <= 1'b0;
      lock           <= 1'b0;
      game_over      <= 1'b0;
    end else begin
      refresh <= 1'b0;
      err     <= 1'b0;
      lock    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pending) begin
            cmd_q  <= sel_cmd;
            hard_q <= sel_hard;
            state  <= ST_PROPOSE;
          end
        end
        ST_PROPOSE: begin
          cand_x   <= cur_x;
          cand_y   <= cur_y;
          cand_rot <= cur_rot;
          to_cnt   <= TO_INIT;
          req      <= 1'b1;
          state    <= ST_WAIT;
          case (cmd_q)
            CMD_ROT: cand_rot <= rot_nxt;
            CMD_LEFT: begin
              if (cur_x == '0) begin
                req   <= 1'b0;
                state <= ST_IDLE;
              end else begin
                cand_x <= cur_x - POS_W'(1);
              end
            end
            CMD_RIGHT: begin
              if (cur_x >= X_LAST) begin
                req   <= 1'b0;
                state <= ST_IDLE;
              end else begin
                cand_x <= cur_x + POS_W'(1);
              end
            end
            CMD_DOWN: begin
              if (cur_y >= Y_LAST) begin
                req   <= 1'b0;
                lock  <= 1'b1;
                state <= ST_LOCK;
              end else begin
                cand_y <= cur_y + POS_W'(1);
              end
            end
          endcase
        end
        ST_WAIT: begin
          if (resolve) begin
            req <= 1'b0;
            if (!hit_eff) begin
              refresh        <= 1'b1;
              block_pos_x_in <= cand_x;
              block_pos_y_in <= cand_y;
              rotate_in      <= cand_rot;
              state          <= ST_COMMIT;
            end else if (cmd_q == CMD_DOWN) begin
              lock  <= 1'b1;
              state <= ST_LOCK;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            to_cnt <= to_cnt - TO_W'(1);
          end
        end
        // Hard drop loops straight back; cur_* has taken the commit by then.
        ST_COMMIT: state <= hard_q ? ST_PROPOSE : ST_IDLE;
        ST_LOCK: begin
          err            <= 1'b1;
          block_pos_x_in <= SP_X;
          block_pos_y_in <= SP_Y;
          rotate_in      <= '0;
          state          <= ST_SPAWN;
        end
        ST_SPAWN: begin
          cand_x   <= SP_X;
          cand_y   <= SP_Y;
          cand_rot <= '0;
          to_cnt   <= TO_INIT;
          req      <= 1'b1;
          state    <= ST_SPAWN_WAIT;
        end
        ST_SPAWN_WAIT: begin
          if (resolve) begin
            req <= 1'b0;
            if (hit_eff) begin
              game_over <= 1'b1;
              state     <= ST_OVER;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            to_cnt <= to_cnt - TO_W'(1);
          end
        end
        ST_OVER: state <= ST_OVER;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
